// File: rtl/shmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shmem_pkg
//  Description : Shared definitions for the multi-port banked scratch memory:
//                default geometry constants, a constant-evaluable clog2 and
//                helpers for locating a port's slice inside a flattened bus.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package shmem_pkg;

    localparam int C_NUM_PORTS = 8;
    localparam int C_DEPTH     = 4;
    localparam int C_WIDTH     = 32;

    // Ceiling log2, usable in parameter/port-width context. Returns at least 1
    // for any value >= 2, which is all this memory accepts.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Lowest bit of element idx in a flattened bus of w-bit elements.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

    // Successor of idx in a ring of n entries.
    function automatic int ring_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : shmem_pkg
`default_nettype wire

// File: rtl/shmem_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : shmem_rr_arb
//  Description : Round-robin arbiter for one memory bank. Picks the first
//                requesting port at or after the rotating pointer (ascending,
//                wrapping) and advances the pointer past the winner.
//                Build option SHMEM_OWNER_PRIO_EN: the owner port wins
//                outright whenever it requests, and such wins leave the
//                pointer untouched so the other ports keep rotating fairly.
//  Ports       : clk_in, rst (async, active-high)
//                req       - request vector, one bit per port
//                owner     - index of the port that owns this bank
//                gnt       - one-hot grant (combinational, zero during rst)
//                gnt_valid - some port is granted this cycle
//                gnt_idx   - index of the granted port
//  Revision    : 1.0 - initial release
// ============================================================================
module shmem_rr_arb
    import shmem_pkg::*;
#(
    parameter  int NUM_PORTS = C_NUM_PORTS,
    localparam int BW        = clog2(NUM_PORTS)
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [BW-1:0]        owner,
    output logic [NUM_PORTS-1:0] gnt,
    output logic                 gnt_valid,
    output logic [BW-1:0]        gnt_idx
);

    logic [BW-1:0] r_ptr;
    logic          w_owner_hit;
    logic          w_rr_valid;
    logic [BW-1:0] w_rr_idx;

`ifdef SHMEM_OWNER_PRIO_EN
    assign w_owner_hit = req[owner];
`else
    logic w_unused_owner;
    assign w_owner_hit    = 1'b0;
    assign w_unused_owner = ^owner;
`endif

    // Rotating search from r_ptr. When the owner wins by priority its request
    // is irrelevant to the rotation result, which is discarded below.
    always_comb begin
        int idx;
        w_rr_valid = 1'b0;
        w_rr_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!w_rr_valid && req[idx]) begin
                w_rr_valid = 1'b1;
                w_rr_idx   = BW'(idx);
            end
        end
    end

    always_comb begin
        gnt_valid = (w_owner_hit || w_rr_valid) && !rst;
        gnt_idx   = w_owner_hit ? owner : w_rr_idx;
        gnt       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            gnt[i] = gnt_valid && (gnt_idx == BW'(i));
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_rr_valid && !w_owner_hit) begin
            r_ptr <= BW'(ring_next(int'(w_rr_idx), NUM_PORTS));
        end
    end

endmodule : shmem_rr_arb
`default_nettype wire

// File: rtl/shared_bank_mem.sv
`default_nettype none
// ============================================================================
//  Module      : shared_bank_mem
//  Description : Multi-port shared scratch memory, NUM_PORTS banks of
//                DEPTH x WIDTH words. Any port may access any bank; each bank
//                has its own round-robin arbiter so distinct banks are served
//                in parallel. Grants are combinational, reads return one cycle
//                later with an rvalid pulse.
//                Build option SHMEM_OWNER_PRIO_EN gives port b absolute
//                priority on bank b (see shmem_rr_arb).
//  Ports       : clk_in, rst (async, active-high)
//                req/we      - per-port request and write-enable
//                bank/addr   - per-port target bank and word address (flat)
//                wdata       - per-port write data (flat)
//                gnt         - per-port combinational grant
//                rvalid      - per-port registered read-data strobe
//                rdata       - per-port registered read data (flat, holds)
//  Revision    : 1.0 - initial release
// ============================================================================
module shared_bank_mem
    import shmem_pkg::*;
#(
    parameter  int NUM_PORTS = C_NUM_PORTS,
    parameter  int DEPTH     = C_DEPTH,
    parameter  int WIDTH     = C_WIDTH,
    localparam int AW        = clog2(DEPTH),
    localparam int BW        = clog2(NUM_PORTS)
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       req,
    input  logic [NUM_PORTS-1:0]       we,
    input  logic [NUM_PORTS*BW-1:0]    bank,
    input  logic [NUM_PORTS*AW-1:0]    addr,
    input  logic [NUM_PORTS*WIDTH-1:0] wdata,
    output logic [NUM_PORTS-1:0]       gnt,
    output logic [NUM_PORTS-1:0]       rvalid,
    output logic [NUM_PORTS*WIDTH-1:0] rdata
);

    // Per-port views of the flattened request buses.
    logic [BW-1:0]    w_bank_sel [NUM_PORTS];
    logic [AW-1:0]    w_addr     [NUM_PORTS];
    logic [WIDTH-1:0] w_wdata    [NUM_PORTS];

    // Per-bank arbitration: which ports ask for the bank, and who won.
    logic [NUM_PORTS-1:0] w_bank_req [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_bank_gnt [NUM_PORTS];
    logic                 w_bank_vld [NUM_PORTS];
    logic [BW-1:0]        w_bank_idx [NUM_PORTS];

    logic [WIDTH-1:0] r_mem [NUM_PORTS][DEPTH];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_bank_sel[p] = bank [slice_lo(p, BW)    +: BW];
            w_addr[p]     = addr [slice_lo(p, AW)    +: AW];
            w_wdata[p]    = wdata[slice_lo(p, WIDTH) +: WIDTH];
        end
    end

    // Bank decode. A bank index beyond NUM_PORTS-1 matches no bank and so can
    // never be granted.
    always_comb begin
        for (int b = 0; b < NUM_PORTS; b++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                w_bank_req[b][p] = req[p] && (w_bank_sel[p] == BW'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_PORTS; b++) begin : g_bank_arb
        shmem_rr_arb #(
            .NUM_PORTS (NUM_PORTS)
        ) u_arb (
            .clk_in    (clk_in),
            .rst       (rst),
            .req       (w_bank_req[b]),
            .owner     (BW'(b)),
            .gnt       (w_bank_gnt[b]),
            .gnt_valid (w_bank_vld[b]),
            .gnt_idx   (w_bank_idx[b])
        );
    end

    // A port targets a single bank, so at most one bank grant vector has its
    // bit set; OR-reducing is therefore a plain merge.
    always_comb begin
        gnt = '0;
        for (int b = 0; b < NUM_PORTS; b++) begin
            gnt = gnt | w_bank_gnt[b];
        end
    end

    // Memory writes: each bank takes at most its one winner's write.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_PORTS; b++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    r_mem[b][a] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < NUM_PORTS; b++) begin
                if (w_bank_vld[b] && we[w_bank_idx[b]]) begin
                    r_mem[b][w_addr[w_bank_idx[b]]] <= w_wdata[w_bank_idx[b]];
                end
            end
        end
    end

    // Read return path. The granted port's bank is exclusively its own this
    // cycle, so the value read is the bank content before this edge.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rvalid[p] <= gnt[p] && !we[p];
                if (gnt[p] && !we[p]) begin
                    rdata[slice_lo(p, WIDTH) +: WIDTH] <= r_mem[w_bank_sel[p]][w_addr[p]];
                end
            end
        end
    end

endmodule : shared_bank_mem
`default_nettype wire

// File: tb/tb_shared_bank_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shared_bank_mem
//  Description : Self-checking bench for shared_bank_mem with a behavioural
//                model of banks, rotation pointers and read returns.
//                Honours SHMEM_OWNER_PRIO_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_bank_mem;

    localparam int N  = 8;
    localparam int D  = 4;
    localparam int W  = 32;
    localparam int BW = 3;
    localparam int AW = 2;

    logic             clk_in = 1'b0;
    logic             rst    = 1'b1;
    logic [N-1:0]     req    = '0;
    logic [N-1:0]     we     = '0;
    logic [N*BW-1:0]  bank   = '0;
    logic [N*AW-1:0]  addr   = '0;
    logic [N*W-1:0]   wdata  = '0;
    logic [N-1:0]     gnt;
    logic [N-1:0]     rvalid;
    logic [N*W-1:0]   rdata;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_mem    [N][D];
    int           m_ptr    [N];
    logic [W-1:0] m_rdata  [N];
    logic [N-1:0] m_rvalid;
    logic [N-1:0] last_gnt;

    shared_bank_mem #(.NUM_PORTS(N), .DEPTH(D), .WIDTH(W)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .bank   (bank),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] dut_rdata(input int p);
        return rdata[p*W +: W];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < N; b++) begin
            m_ptr[b]   = 0;
            m_rdata[b] = '0;
            for (int a = 0; a < D; a++) m_mem[b][a] = '0;
        end
        m_rvalid = '0;
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input int b,
                            input int a, input logic [W-1:0] d);
        req[p]             = r;
        we[p]              = w;
        bank[p*BW +: BW]   = BW'(b);
        addr[p*AW +: AW]   = AW'(a);
        wdata[p*W +: W]    = d;
    endtask

    task automatic idle_all();
        req = '0; we = '0;
    endtask

    // Spec-level winner choice for bank b: owner first if enabled, otherwise
    // the first requesting port met walking up from the pointer.
    function automatic int winner(input int b);
        int p;
`ifdef SHMEM_OWNER_PRIO_EN
        if (req[b] && int'(bank[b*BW +: BW]) == b) return b;
`endif
        for (int k = 0; k < N; k++) begin
            p = (m_ptr[b] + k) % N;
            if (req[p] && int'(bank[p*BW +: BW]) == b) return p;
        end
        return -1;
    endfunction

    // One clock of traffic: inputs are already set by the caller.
    task automatic do_cycle();
        int           win [N];
        logic [N-1:0] eg;
        int           p, a;
        eg = '0;
        for (int b = 0; b < N; b++) begin
            win[b] = winner(b);
            if (win[b] >= 0) eg[win[b]] = 1'b1;
        end
        #2;
        last_gnt = gnt;
        chk("gnt", gnt, eg);
        @(posedge clk_in);
        m_rvalid = '0;
        for (int b = 0; b < N; b++) begin
            if (win[b] >= 0) begin
                p = win[b];
                a = int'(addr[p*AW +: AW]);
                if (we[p]) m_mem[b][a] = wdata[p*W +: W];
                else begin
                    m_rdata[p]  = m_mem[b][a];
                    m_rvalid[p] = 1'b1;
                end
`ifdef SHMEM_OWNER_PRIO_EN
                if (p != b) m_ptr[b] = (p + 1) % N;
`else
                m_ptr[b] = (p + 1) % N;
`endif
            end
        end
        #1;
        chk("rvalid", rvalid, m_rvalid);
        for (int q = 0; q < N; q++) chk($sformatf("rdata[%0d]", q), dut_rdata(q), m_rdata[q]);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_gnt", gnt, '0);
        chk("rst_rvalid", rvalid, '0);
        chk("rst_rdata", rdata[63:0], '0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        last_gnt = '0;
        @(posedge clk_in);
        #1;
        apply_reset();

        // Reset: fill every bank, then reset mid-cycle with requests pending.
        for (int a = 0; a < D; a++) begin
            for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b1, p, a, W'(32'h1111_0000 + p * 16 + a));
            do_cycle();
        end
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, p, 0, '0);
        #3;
        apply_reset();
        for (int a = 0; a < D; a++) begin
            for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, p, a, '0);
            do_cycle();
            chk("post_rst_zero", dut_rdata(a), '0);
        end

        // Private traffic, all ports in parallel.
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b1, p, 3, W'(32'hA5A5_0000 + p));
        do_cycle();
        chk("priv_wr_gnt", last_gnt, 8'hFF);
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, p, 3, '0);
        do_cycle();
        chk("priv_rd_gnt", last_gnt, 8'hFF);
        chk("priv_rvalid", rvalid, 8'hFF);
        chk("priv_rdata5", dut_rdata(5), 32'hA5A5_0005);

        // Cross-bank exchange.
        idle_all();
        set_port(2, 1'b1, 1'b1, 5, 1, 32'hDEADBEEF);
        do_cycle();
        idle_all();
        set_port(7, 1'b1, 1'b0, 5, 1, '0);
        do_cycle();
        chk("cross_rdata", dut_rdata(7), 32'hDEADBEEF);
        chk("cross_rvalid", rvalid, 8'h80);
        idle_all();
        do_cycle();
        chk("rvalid_drop", rvalid, '0);

        // Contention on bank 4 from reset: 0,3,6 rotating.
        apply_reset();
        idle_all();
        set_port(0, 1'b1, 1'b0, 4, 0, '0);
        set_port(3, 1'b1, 1'b0, 4, 0, '0);
        set_port(6, 1'b1, 1'b0, 4, 0, '0);
        for (int k = 0; k < 6; k++) begin
            logic [N-1:0] seq [3];
            seq[0] = 8'h01; seq[1] = 8'h08; seq[2] = 8'h40;
            do_cycle();
            chk($sformatf("rr_seq%0d", k), last_gnt, seq[k % 3]);
        end

        // Pointer wrap on bank 1.
        apply_reset();
        idle_all();
        set_port(6, 1'b1, 1'b0, 1, 0, '0);
        do_cycle();
        idle_all();
        set_port(0, 1'b1, 1'b0, 1, 2, '0);
        set_port(7, 1'b1, 1'b0, 1, 2, '0);
        do_cycle();
        chk("wrap_first", last_gnt, 8'h80);
        set_port(7, 1'b0, 1'b0, 1, 2, '0);
        do_cycle();
        chk("wrap_second", last_gnt, 8'h01);

        // Owner port 4 versus port 1 on bank 4.
        apply_reset();
        idle_all();
        set_port(1, 1'b1, 1'b0, 4, 0, '0);
        set_port(4, 1'b1, 1'b0, 4, 0, '0);
        for (int k = 0; k < 4; k++) begin
            do_cycle();
`ifdef SHMEM_OWNER_PRIO_EN
            chk($sformatf("owner%0d", k), last_gnt, 8'h10);
`else
            chk($sformatf("owner%0d", k), last_gnt, (k % 2 == 0) ? 8'h02 : 8'h10);
`endif
        end

        // Randomised traffic; ungranted requesters hold their request.
        idle_all();
        last_gnt = '0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!(req[p] && !last_gnt[p])) begin
                    set_port(p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                             int'($urandom_range(0, N - 1)), int'($urandom_range(0, D - 1)), $urandom);
                end
            end
            do_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shared_bank_mem
`default_nettype wire
